// File: rtl/frame_update_scheduler.sv
// Per-frame update sweep scheduler: on the vertical-blank trigger it grants requesters 0..3 in turn.
// Optional per-request ack timeout is enabled by defining FRAME_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module frame_update_scheduler #(
  parameter int unsigned ACTIVE_ROWS    = 480,
  parameter int unsigned TOTAL_ROWS     = 525,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [9:0] i_Col_Count,
  input  logic [9:0] i_Row_Count,
  input  logic       i_Game_Active,
  input  logic [3:0] i_Req_Enable,
  input  logic [3:0] i_Update_Ack,
  output logic [3:0] o_Update_Req,
  output logic       o_Frame_Start,
  output logic       o_Sweep_Done,
  output logic       o_Busy,
  output logic [7:0] o_Frame_Count,
  output logic       o_Overrun,
  output logic [3:0] o_Timeout
);

  if (ACTIVE_ROWS >= TOTAL_ROWS || TOTAL_ROWS > 1024 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("frame_update_scheduler: invalid parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StSelect, StWaitAck, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] req_q, req_d;
  logic       frame_start_q, frame_start_d;
  logic       sweep_done_q, sweep_done_d;
  logic       busy_q, busy_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       overrun_q, overrun_d;

  logic       trigger;
  logic       acked;
  logic       tmo_hit;
  logic [3:0] next_req;

  assign trigger  = (32'(i_Row_Count) == ACTIVE_ROWS) && (32'(i_Row_Count) < TOTAL_ROWS) &&
                    (i_Col_Count == 10'd0);
  // Only the bit currently requested can complete it; other ack bits are don't-care.
  assign acked    = |(i_Update_Ack & req_q);
  assign next_req = pending_q & (~pending_q + 4'd1);

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]      timeout_q, timeout_d;

  // Counter is cleared whenever a request (re)asserts, so it measures cycles the request is high.
  assign tmo_hit   = (state_q == StWaitAck) && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign tmo_cnt_d = (state_q == StWaitAck && !acked && !tmo_hit) ? tmo_cnt_q + 1'b1 : '0;
  assign timeout_d = timeout_q | ((tmo_hit && !acked) ? req_q : 4'b0000);
  assign o_Timeout = timeout_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tmo_cnt_q <= '0;
      timeout_q <= 4'b0000;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign o_Timeout = 4'b0000;
`endif

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    req_d         = req_q;
    busy_d        = busy_q;
    frame_cnt_d   = frame_cnt_q;
    overrun_d     = overrun_q;
    frame_start_d = 1'b0;
    sweep_done_d  = 1'b0;

    if (trigger) begin
      frame_start_d = 1'b1;
      frame_cnt_d   = frame_cnt_q + 8'd1;
      if (busy_q) overrun_d = 1'b1;
    end

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (trigger && i_Game_Active) begin
          state_d   = StSelect;
          pending_d = i_Req_Enable;
          busy_d    = 1'b1;
        end
      end
      StSelect, StWaitAck: begin
        // Hand-off happens on the completing edge: old request drops, next one rises together.
        if (state_q == StSelect || acked || tmo_hit) begin
          if (next_req == 4'b0000) begin
            req_d        = 4'b0000;
            state_d      = StDone;
            sweep_done_d = 1'b1;
            busy_d       = 1'b0;
          end else begin
            req_d     = next_req;
            pending_d = pending_q & ~next_req;
            state_d   = StWaitAck;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= StIdle;
      pending_q     <= 4'b0000;
      req_q         <= 4'b0000;
      frame_start_q <= 1'b0;
      sweep_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= 8'd0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      req_q         <= req_d;
      frame_start_q <= frame_start_d;
      sweep_done_q  <= sweep_done_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
    end
  end

  assign o_Update_Req  = req_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Sweep_Done  = sweep_done_q;
  assign o_Busy        = busy_q;
  assign o_Frame_Count = frame_cnt_q;
  assign o_Overrun     = overrun_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: sweep vector table plus overrun, timeout and reset cases.
`timescale 1ns/1ps
module tb_frame_update_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] col, row;
  logic       game;
  logic [3:0] en, ack;
  logic [3:0] req;
  logic       fs, done, busy, overrun;
  logic [7:0] fcnt;
  logic [3:0] tmo;

  always #5 clk = ~clk;

  frame_update_scheduler #(
    .ACTIVE_ROWS   (480),
    .TOTAL_ROWS    (525),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Col_Count  (col),
    .i_Row_Count  (row),
    .i_Game_Active(game),
    .i_Req_Enable (en),
    .i_Update_Ack (ack),
    .o_Update_Req (req),
    .o_Frame_Start(fs),
    .o_Sweep_Done (done),
    .o_Busy       (busy),
    .o_Frame_Count(fcnt),
    .o_Overrun    (overrun),
    .o_Timeout    (tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_cnt = 8'd0;

  typedef struct {
    logic [3:0]  mask;
    int          hold;
    logic [15:0] order;
    int          n;
    int          done_cyc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present the trigger for one edge; returns in the cycle after T.
  task automatic trig();
    row = 10'd480;
    col = 10'd0;
    step();
    row = 10'd100;
    col = 10'd5;
    exp_cnt++;
  endtask

  task automatic run_sweep(input logic [3:0] mask, input int hold, input logic [15:0] exp_order,
                           input int exp_n, input int exp_done);
    logic [15:0] order;
    logic [3:0]  prev;
    int n, run, done_cyc;
    logic bad_hold, bad_busy, bad_hot, busy_at_done;
    en   = mask;
    game = 1'b1;
    ack  = 4'b0000;
    trig();
    check("sweep frame_start", 32'(fs), 32'd1);
    check("sweep frame_count", 32'(fcnt), 32'(exp_cnt));
    check("sweep busy at T+1", 32'(busy), 32'd1);
    en = ~mask;
    order = '0; prev = '0; n = 0; run = 0; done_cyc = -1;
    bad_hold = 1'b0; bad_busy = 1'b0; bad_hot = 1'b0; busy_at_done = 1'b1;
    ack = 4'b1111;
    for (int c = 2; c < 60 && done_cyc < 0; c++) begin
      step();
      if (done) begin
        done_cyc = c;
        busy_at_done = busy;
      end else if (busy !== 1'b1) begin
        bad_busy = 1'b1;
      end
      if ($countones(req) > 1) bad_hot = 1'b1;
      if (req != prev) begin
        if (prev != 4'b0000 && run != hold) bad_hold = 1'b1;
        if (req != 4'b0000) begin
          order = {order[11:0], req};
          n++;
        end
        run = 1;
      end else if (req != 4'b0000) begin
        run++;
      end
      prev = req;
      ack = (~req & 4'b1111) | ((req != 4'b0000 && run == hold) ? req : 4'b0000);
    end
    check("sweep done cycle", 32'(done_cyc), 32'(exp_done));
    check("sweep req order", 32'(order), 32'(exp_order));
    check("sweep req count", 32'(n), 32'(exp_n));
    check("sweep req hold", 32'(bad_hold), 32'd0);
    check("sweep busy during", 32'(bad_busy), 32'd0);
    check("sweep one-hot", 32'(bad_hot), 32'd0);
    check("sweep busy at done", 32'(busy_at_done), 32'd0);
    ack = 4'b0000;
    step();
    check("sweep done pulse width", 32'(done), 32'd0);
    check("sweep idle req", 32'(req), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_l;
    int hi, ok, done_cyc;
    logic bad;
    vecs[0] = '{mask: 4'b1111, hold: 4, order: 16'h1248, n: 4, done_cyc: 18};
    vecs[1] = '{mask: 4'b0101, hold: 4, order: 16'h0014, n: 2, done_cyc: 10};
    vecs[2] = '{mask: 4'b0000, hold: 1, order: 16'h0000, n: 0, done_cyc: 2};
    vecs[3] = '{mask: 4'b1000, hold: 1, order: 16'h0008, n: 1, done_cyc: 3};
    vecs[4] = '{mask: 4'b0110, hold: 2, order: 16'h0024, n: 2, done_cyc: 6};

    rst_n = 1'b0; row = 10'd100; col = 10'd5; game = 1'b0; en = 4'b0000; ack = 4'b0000;
    step(); step();
    check("reset req", 32'(req), 32'd0);
    check("reset frame_start", 32'(fs), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_count", 32'(fcnt), 32'd0);
    check("reset overrun/done/timeout", {27'd0, overrun, done, tmo}, 32'd0);
    rst_n = 1'b1;
    step();

    // Near-miss trigger positions must not fire.
    row = 10'd480; col = 10'd1;
    step();
    row = 10'd479; col = 10'd0;
    step();
    check("near-miss frame_start", 32'(fs), 32'd0);
    row = 10'd100; col = 10'd5;
    step();
    check("near-miss frame_start 2", 32'(fs), 32'd0);
    check("near-miss frame_count", 32'(fcnt), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_sweep(vecs[i].mask, vecs[i].hold, vecs[i].order, vecs[i].n, vecs[i].done_cyc);
    end

    // Paused: frames still counted, no sweep.
    game = 1'b0; en = 4'b1111;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trig();
      if (fs !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      step();
      if (fs !== 1'b0 || busy !== 1'b0 || req !== 4'b0000) bad = 1'b1;
    end
    check("paused pulses/busy/req", 32'(bad), 32'd0);
    check("paused frame_count", 32'(fcnt), 32'(exp_cnt));

    check("overrun before stall", 32'(overrun), 32'd0);
`ifdef FRAME_SCHED_TIMEOUT_EN
    // Requester 1 never acks; requester 2 acks immediately.
    game = 1'b1; en = 4'b0110; ack = 4'b0100;
    trig();
    en = 4'b0000;
    hi = 0; done_cyc = -1;
    for (int c = 2; c < 40 && done_cyc < 0; c++) begin
      step();
      if (req == 4'b0010) hi++;
      if (done) done_cyc = c;
    end
    check("timeout req1 high cycles", 32'(hi), 32'd16);
    check("timeout done cycle", 32'(done_cyc), 32'd19);
    check("timeout flags", 32'(tmo), 32'h2);
    ack = 4'b0000;
    step(); step();
`else
    // Requester 1 never acks: request held indefinitely, next trigger overruns.
    game = 1'b1; en = 4'b0010; ack = 4'b0000;
    trig();
    ok = 0;
    for (int c = 2; c < 42; c++) begin
      step();
      if (req == 4'b0010 && busy == 1'b1) ok++;
    end
    check("stall req held", 32'(ok), 32'd40);
    check("stall timeout const", 32'(tmo), 32'd0);
    trig();
    check("stall overrun", 32'(overrun), 32'd1);
    check("stall frame_start", 32'(fs), 32'd1);
    check("stall req kept", 32'(req), 32'h2);
    ack = 4'b0010;
    step();
    check("stall done after ack", 32'(done), 32'd1);
    ack = 4'b0000;
    step(); step();
`endif

    // Retrigger mid-sweep: overrun set, current sweep finishes, no restart.
    game = 1'b1; en = 4'b0001; ack = 4'b0000;
    trig();
    step(); step();
    trig();
    check("overrun flag", 32'(overrun), 32'd1);
    check("overrun frame_start", 32'(fs), 32'd1);
    check("overrun req unchanged", 32'(req), 32'h1);
    check("overrun frame_count", 32'(fcnt), 32'(exp_cnt));
    ack = 4'b0001;
    step();
    check("overrun sweep done", 32'(done), 32'd1);
    ack = 4'b0000;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (req !== 4'b0000 || busy !== 1'b0) bad = 1'b1;
    end
    check("overrun no restart", 32'(bad), 32'd0);

    // Reset mid-WAIT_ACK at frame count 200.
    game = 1'b0;
    while (exp_cnt != 8'd200) trig();
    check("count reaches 200", 32'(fcnt), 32'd200);
    game = 1'b1; en = 4'b1111; ack = 4'b0000;
    trig();
    step(); step();
    check("pre-reset req", 32'(req), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset req", 32'(req), 32'd0);
    check("async reset count/busy", {23'd0, fcnt, busy}, 32'd0);
    check("async reset flags", {28'd0, fs, done, overrun, |tmo}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    bad = 1'b0;
    prev_l = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      prev_l = prev_l | req;
      if (busy !== 1'b0) bad = 1'b1;
    end
    check("post-reset no request", {27'd0, bad, prev_l}, 32'd0);
    run_sweep(4'b0011, 2, 16'h0012, 2, 6);

    // Frame counter wrap.
    game = 1'b0;
    while (exp_cnt != 8'd255) trig();
    check("count reaches 255", 32'(fcnt), 32'd255);
    trig();
    check("count wraps to 0", 32'(fcnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_update_scheduler.md
FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

Interface
REQ-001 Parameter ACTIVE_ROWS, default 480: first vertical-blank row index; frame trigger row.
REQ-002 Parameter TOTAL_ROWS, default 525: rows per frame; i_Row_Count SHALL stay below this.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum ack wait per requester when FRAME_SCHED_TIMEOUT_EN is defined.
REQ-004 i_Clk  input  1  pixel clock, 25 MHz; all state SHALL update on its rising edge.
REQ-005 i_Rst_L  input  1  reset, asynchronous assert, active-low.
REQ-006 i_Col_Count  input  10  current column from the sync-pulse counter.
REQ-007 i_Row_Count  input  10  current row from the sync-pulse counter.
REQ-008 i_Game_Active  input  1  1 = run update sweeps; 0 = paused.
REQ-009 i_Req_Enable  input  4  per-requester enable mask (bit 0 = P1 paddle, 1 = P2 paddle, 2 = ball, 3 = score).
REQ-010 i_Update_Ack  input  4  per-requester completion acknowledge.
REQ-011 o_Update_Req  output  4  one-hot-or-zero update request.
REQ-012 o_Frame_Start  output  1  one-cycle pulse per frame trigger.
REQ-013 o_Sweep_Done  output  1  one-cycle pulse when a sweep completes.
REQ-014 o_Busy  output  1  high while a sweep is in progress.
REQ-015 o_Frame_Count  output  8  frames since reset, wraps 255 -> 0.
REQ-016 o_Overrun  output  1  sticky: a trigger arrived while busy.
REQ-017 o_Timeout  output  4  sticky per-requester timeout flags.

Function
REQ-018 Trigger SHALL be sampled at edge T when i_Row_Count == ACTIVE_ROWS and i_Col_Count == 0; exactly one trigger per frame.
REQ-019 On trigger, o_Frame_Start SHALL be high for the single cycle after T, and o_Frame_Count SHALL increment on that edge, regardless of i_Game_Active or busy state.
REQ-020 FSM states SHALL be IDLE, SELECT, WAIT_ACK, DONE; IDLE -> SELECT on trigger when i_Game_Active == 1 and not busy.
REQ-021 i_Req_Enable SHALL be latched at T; later changes SHALL NOT affect the current sweep.
REQ-022 SELECT SHALL pick the lowest-index enabled, not-yet-served requester in fixed order 0,1,2,3; the first request SHALL assert at edge T+2.
REQ-023 WAIT_ACK SHALL hold exactly one o_Update_Req bit high until i_Update_Ack of that bit is sampled 1.
REQ-024 At the edge sampling that ack, the current request SHALL drop and the next enabled request (if any) SHALL assert on that same edge; no gap cycle, no overlap.
REQ-025 Ack bits for non-requested requesters SHALL be ignored.
REQ-026 After the last enabled requester is acked, FSM SHALL enter DONE: o_Sweep_Done high one cycle, o_Busy low from that same cycle, then IDLE.
REQ-027 Latched mask == 0: SELECT -> DONE directly; o_Sweep_Done SHALL pulse at T+2 with no requests.
REQ-028 o_Busy SHALL be high from T+1 through the last cycle before o_Sweep_Done.
REQ-029 Trigger while o_Busy: no new sweep, current sweep continues unaffected, o_Overrun set to 1.
REQ-030 i_Game_Active falling mid-sweep SHALL NOT abort the sweep.

Reset
REQ-031 While i_Rst_L == 0: FSM = IDLE, o_Update_Req = 0, o_Frame_Start = 0, o_Sweep_Done = 0, o_Busy = 0, o_Frame_Count = 0, o_Overrun = 0, o_Timeout = 0, timeout counter = 0.
REQ-032 Reset asserted mid-sweep SHALL drop all requests immediately (asynchronously); after release, no sweep SHALL begin before the next trigger.

Configuration
REQ-033 Macro FRAME_SCHED_TIMEOUT_EN defined: a counter SHALL restart at each request assertion; if no ack after TIMEOUT_CYCLES cycles with request high, the request SHALL drop, o_Timeout[k] SHALL set sticky, and the sweep SHALL advance as if acked.
REQ-034 Macro undefined: no timeout counter; WAIT_ACK waits indefinitely; o_Timeout SHALL be constant 0.

Verification
REQ-035 Mask 4'b1111, each ack 3 cycles after request -> Req sequence 0001,0010,0100,1000, each high 4 cycles, back-to-back; Sweep_Done one cycle; Frame_Count +1.
REQ-036 Mask 4'b0101 -> only Req 0001 then 0100; Busy low after Done; Frame_Count increments.
REQ-037 Mask 4'b0000 -> Frame_Start at T+1, Sweep_Done at T+2, Update_Req stays 0.
REQ-038 i_Game_Active = 0 for 3 frames -> 3 Frame_Start pulses, Frame_Count +3, no requests, Busy stays 0.
REQ-039 Requester 1 never acks, macro defined, TIMEOUT_CYCLES = 16 -> Req 0010 high exactly 16 cycles, o_Timeout = 4'b0010, sweep completes; macro undefined -> Req 0010 held, next trigger sets o_Overrun = 1.
REQ-040 i_Rst_L pulsed low mid-WAIT_ACK, Frame_Count = 200 -> all outputs 0 immediately; no request until next trigger; Frame_Count restarts at 1.
